sig_gen_gate: RTL and testbench

Programmable square-wave source and gate generator that drives the frequency-counter measurement path. Produces `sigout` with a programmable half-period in `clck` cycles and a `gate` window of programmable length. Also counts the `sigout` rising edges emitted inside the window, so a bench or self-test can compare that count against the counter/display result.

---
 rtl/sig_gen_gate_if.sv | 25 ++
 rtl/sig_gen_gate.sv | 121 ++++++++++++
 tb/tb_sig_gen_gate.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sig_gen_gate_if.sv
// Configuration/control and result bundle between a stimulus driver and sig_gen_gate.
// master drives the config and strobes; slave (the generator) drives the waveform and status.
interface sig_gen_gate_if #(
    parameter int unsigned CNT_W = 32
);
    logic [CNT_W-1:0] half_period;
    logic [CNT_W-1:0] gate_len;
    logic             load;
    logic             start;
    logic             sigout;
    logic             gate;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] edge_cnt;

    modport master (
        output half_period, gate_len, load, start,
        input  sigout, gate, busy, done, edge_cnt
    );

    modport slave (
        input  half_period, gate_len, load, start,
        output sigout, gate, busy, done, edge_cnt
    );
endinterface

// File: rtl/sig_gen_gate.sv
// Square-wave source with a programmable gate window.
// Counts the sigout rising edges that fall inside the window.
module sig_gen_gate #(
    parameter int unsigned CNT_W = 32
) (
    input  logic            clck,
    input  logic            rst_n,
    sig_gen_gate_if.slave   bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       r_state,     w_state_nxt;
    logic [CNT_W-1:0] r_hp,        w_hp_nxt;
    logic [CNT_W-1:0] r_gl,        w_gl_nxt;
    logic [CNT_W-1:0] r_div_cnt,   w_div_cnt_nxt;
    logic [CNT_W-1:0] r_win_cnt,   w_win_cnt_nxt;
    logic [CNT_W-1:0] r_edge_cnt,  w_edge_cnt_nxt;
    logic             r_sigout,    w_sigout_nxt;
    logic             r_gate,      w_gate_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_done,      w_done_nxt;
    logic             w_load_acc;
    logic             w_start_acc;
    logic             w_rise;

    // State register: every output and counter lives here
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hp       <= '0;
            r_gl       <= '0;
            r_div_cnt  <= '0;
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_sigout   <= 1'b0;
            r_gate     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hp       <= w_hp_nxt;
            r_gl       <= w_gl_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_win_cnt  <= w_win_cnt_nxt;
            r_edge_cnt <= w_edge_cnt_nxt;
            r_sigout   <= w_sigout_nxt;
            r_gate     <= w_gate_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state: config capture, free-running divider, window FSM, edge counter
    always_comb begin
        w_state_nxt    = r_state;
        w_hp_nxt       = r_hp;
        w_gl_nxt       = r_gl;
        w_div_cnt_nxt  = r_div_cnt;
        w_win_cnt_nxt  = r_win_cnt;
        w_edge_cnt_nxt = r_edge_cnt;
        w_sigout_nxt   = r_sigout;
        w_gate_nxt     = r_gate;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        w_load_acc  = bus.load && (r_state == IDLE);
        // load wins over a coincident start
        w_start_acc = bus.start && !bus.load && (r_state == IDLE) && (r_gl != '0);

        if (w_load_acc) begin
            w_hp_nxt      = bus.half_period;
            w_gl_nxt      = bus.gate_len;
            w_div_cnt_nxt = '0;
            w_sigout_nxt  = 1'b0;
        end else if (r_hp == '0) begin
            w_div_cnt_nxt = '0;
            w_sigout_nxt  = 1'b0;
        end else if (r_div_cnt == r_hp - CNT_W'(1)) begin
            w_div_cnt_nxt = '0;
            w_sigout_nxt  = ~r_sigout;
        end else begin
            w_div_cnt_nxt = r_div_cnt + CNT_W'(1);
        end

        case (r_state)
            IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt    = RUN;
                    w_gate_nxt     = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_win_cnt_nxt  = r_gl - CNT_W'(1);
                    w_edge_cnt_nxt = '0;
                end
            end
            RUN: begin
                if (r_win_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_gate_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_win_cnt_nxt = r_win_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // A rise counts only if gate is high after the same edge
        w_rise = w_sigout_nxt && !r_sigout;
        if (w_rise && w_gate_nxt && (w_edge_cnt_nxt != '1)) begin
            w_edge_cnt_nxt = w_edge_cnt_nxt + CNT_W'(1);
        end
    end

    assign bus.sigout   = r_sigout;
    assign bus.gate     = r_gate;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.edge_cnt = r_edge_cnt;
endmodule

// File: tb/tb_sig_gen_gate.sv
// Scoreboard bench for sig_gen_gate: expected window results are queued at start
// and compared against an independent edge/gate measurement when done pulses.
module tb_sig_gen_gate;
    localparam int unsigned CNT_W = 32;

    logic clck  = 1'b0;
    logic rst_n = 1'b0;

    sig_gen_gate_if #(.CNT_W(CNT_W)) bus ();

    sig_gen_gate #(.CNT_W(CNT_W)) dut (
        .clck  (clck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clck = ~clck;

    typedef struct {
        int gate_cycles;
        int edges;
        int period;
    } exp_t;

    typedef struct {
        int first_gate;
        int gate_hi;
        int sig_hi;
        int rises;
        int per_min;
        int per_max;
        int busy_bad;
        int gate_at_done;
        int dut_cnt;
        int to;
    } win_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Tasks start and end just after a falling edge
    task automatic do_load(input int hp, input int gl);
        bus.half_period = CNT_W'(hp);
        bus.gate_len    = CNT_W'(gl);
        bus.load        = 1'b1;
        @(negedge clck);
        bus.load        = 1'b0;
    endtask

    // Caller has just raised start; watch the window until done or budget expiry
    task automatic run_window(input int budget, input int poke_at, output win_t w);
        int prev;
        int last;
        w = '{first_gate: 0, gate_hi: 0, sig_hi: 0, rises: 0, per_min: 1000000,
              per_max: 0, busy_bad: 0, gate_at_done: 0, dut_cnt: -1, to: 1};
        prev = int'(bus.sigout);
        last = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clck);
            bus.start = 1'b0;
            bus.load  = 1'b0;
            if (i == poke_at) begin
                bus.half_period = CNT_W'(7);
                bus.load        = 1'b1;
                bus.start       = 1'b1;
            end
            if (i == 0) w.first_gate = int'(bus.gate);
            if (bus.gate) w.gate_hi++;
            if (bus.gate && bus.sigout) w.sig_hi++;
            if (bus.busy !== bus.gate) w.busy_bad++;
            if (prev == 0 && bus.sigout) begin
                if (bus.gate) w.rises++;
                if (last >= 0) begin
                    if (i - last < w.per_min) w.per_min = i - last;
                    if (i - last > w.per_max) w.per_max = i - last;
                end
                last = i;
            end
            prev = int'(bus.sigout);
            if (bus.done) begin
                w.to           = 0;
                w.gate_at_done = int'(bus.gate);
                w.dut_cnt      = int'(bus.edge_cnt);
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.half_period = '0;
        bus.gate_len    = '0;
        bus.load        = 1'b0;
        bus.start       = 1'b0;
        rst_n           = 1'b0;
        repeat (2) @(negedge clck);
        n_vec++; if (bus.sigout !== 1'b0) begin n_err++; $display("FAIL reset_sigout: got %0b want 0", bus.sigout); end
        n_vec++; if (bus.gate !== 1'b0) begin n_err++; $display("FAIL reset_gate: got %0b want 0", bus.gate); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", bus.done); end
        n_vec++; if (bus.edge_cnt !== '0) begin n_err++; $display("FAIL reset_edge_cnt: got %0d want 0", bus.edge_cnt); end
        rst_n = 1'b1;
        @(negedge clck);
    endtask

    task automatic test_basic();
        win_t w;
        exp_t e;
        int   first_rise;
        do_load(5, 100);
        first_rise = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clck);
            if (bus.sigout) begin first_rise = k; break; end
        end
        n_vec++; if (first_rise !== 5) begin n_err++; $display("FAIL basic_first_rise: got %0d want 5", first_rise); end
        sb.push_back('{gate_cycles: 100, edges: 10, period: 10});
        bus.start = 1'b1;
        run_window(300, -1, w);
        e = sb.pop_front();
        n_vec++; if (w.to !== 0) begin n_err++; $display("FAIL basic_timeout: got %0d want 0", w.to); end
        n_vec++; if (w.first_gate !== 1) begin n_err++; $display("FAIL basic_gate_rise: got %0d want 1", w.first_gate); end
        n_vec++; if (w.gate_hi !== e.gate_cycles) begin n_err++; $display("FAIL basic_gate_len: got %0d want %0d", w.gate_hi, e.gate_cycles); end
        n_vec++; if (w.busy_bad !== 0) begin n_err++; $display("FAIL basic_busy_tracks_gate: got %0d want 0", w.busy_bad); end
        n_vec++; if (w.per_min !== e.period || w.per_max !== e.period) begin n_err++; $display("FAIL basic_period: got %0d..%0d want %0d", w.per_min, w.per_max, e.period); end
        n_vec++; if (w.rises !== e.edges) begin n_err++; $display("FAIL basic_model_edges: got %0d want %0d", w.rises, e.edges); end
        n_vec++; if (w.dut_cnt !== e.edges) begin n_err++; $display("FAIL basic_edge_cnt: got %0d want %0d", w.dut_cnt, e.edges); end
        n_vec++; if (w.gate_at_done !== 0) begin n_err++; $display("FAIL basic_gate_at_done: got %0d want 0", w.gate_at_done); end
        @(negedge clck);
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %0b want 0", bus.done); end
        repeat (5) @(negedge clck);
        n_vec++; if (int'(bus.edge_cnt) !== e.edges) begin n_err++; $display("FAIL basic_edge_cnt_hold: got %0d want %0d", bus.edge_cnt, e.edges); end
    endtask

    task automatic test_back_to_back();
        win_t w;
        exp_t e;
        do_load(1, 8);
        sb.push_back('{gate_cycles: 8, edges: 4, period: 2});
        sb.push_back('{gate_cycles: 8, edges: 4, period: 2});
        bus.start = 1'b1;
        run_window(50, -1, w);
        e = sb.pop_front();
        n_vec++; if (w.to !== 0) begin n_err++; $display("FAIL b2b_first_timeout: got %0d want 0", w.to); end
        n_vec++; if (w.gate_hi !== e.gate_cycles) begin n_err++; $display("FAIL b2b_first_gate_len: got %0d want %0d", w.gate_hi, e.gate_cycles); end
        n_vec++; if (w.dut_cnt !== e.edges) begin n_err++; $display("FAIL b2b_first_edge_cnt: got %0d want %0d", w.dut_cnt, e.edges); end
        bus.start = 1'b1;
        run_window(50, -1, w);
        e = sb.pop_front();
        n_vec++; if (w.to !== 0) begin n_err++; $display("FAIL b2b_second_timeout: got %0d want 0", w.to); end
        n_vec++; if (w.first_gate !== 1) begin n_err++; $display("FAIL b2b_second_accepted: got %0d want 1", w.first_gate); end
        n_vec++; if (w.gate_hi !== e.gate_cycles) begin n_err++; $display("FAIL b2b_second_gate_len: got %0d want %0d", w.gate_hi, e.gate_cycles); end
        n_vec++; if (w.per_min !== e.period || w.per_max !== e.period) begin n_err++; $display("FAIL b2b_period: got %0d..%0d want %0d", w.per_min, w.per_max, e.period); end
        n_vec++; if (w.dut_cnt !== e.edges) begin n_err++; $display("FAIL b2b_second_edge_cnt: got %0d want %0d", w.dut_cnt, e.edges); end
        @(negedge clck);
    endtask

    task automatic test_hp_zero();
        win_t w;
        exp_t e;
        do_load(0, 50);
        sb.push_back('{gate_cycles: 50, edges: 0, period: 0});
        bus.start = 1'b1;
        run_window(100, -1, w);
        e = sb.pop_front();
        n_vec++; if (w.to !== 0) begin n_err++; $display("FAIL hp0_timeout: got %0d want 0", w.to); end
        n_vec++; if (w.gate_hi !== e.gate_cycles) begin n_err++; $display("FAIL hp0_gate_len: got %0d want %0d", w.gate_hi, e.gate_cycles); end
        n_vec++; if (w.sig_hi !== 0) begin n_err++; $display("FAIL hp0_sigout_high: got %0d want 0", w.sig_hi); end
        n_vec++; if (w.dut_cnt !== e.edges) begin n_err++; $display("FAIL hp0_edge_cnt: got %0d want %0d", w.dut_cnt, e.edges); end
        @(negedge clck);
    endtask

    task automatic test_gl_zero();
        int active;
        do_load(3, 0);
        bus.start = 1'b1;
        active    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clck);
            bus.start = 1'b0;
            if (bus.gate || bus.busy || bus.done) active++;
        end
        n_vec++; if (active !== 0) begin n_err++; $display("FAIL gl0_no_window: got %0d active cycles want 0", active); end
    endtask

    task automatic test_run_ignore();
        win_t w;
        exp_t e;
        do_load(3, 60);
        sb.push_back('{gate_cycles: 60, edges: 10, period: 6});
        bus.start = 1'b1;
        run_window(200, 20, w);
        e = sb.pop_front();
        n_vec++; if (w.to !== 0) begin n_err++; $display("FAIL run_ignore_timeout: got %0d want 0", w.to); end
        n_vec++; if (w.gate_hi !== e.gate_cycles) begin n_err++; $display("FAIL run_ignore_gate_len: got %0d want %0d", w.gate_hi, e.gate_cycles); end
        n_vec++; if (w.per_min !== e.period || w.per_max !== e.period) begin n_err++; $display("FAIL run_ignore_period: got %0d..%0d want %0d", w.per_min, w.per_max, e.period); end
        n_vec++; if (w.dut_cnt !== e.edges) begin n_err++; $display("FAIL run_ignore_edge_cnt: got %0d want %0d", w.dut_cnt, e.edges); end
        @(negedge clck);
    endtask

    task automatic test_load_start_same();
        win_t w;
        exp_t e;
        int   busy_seen;
        do_load(2, 20);
        bus.half_period = CNT_W'(4);
        bus.gate_len    = CNT_W'(16);
        bus.load        = 1'b1;
        bus.start       = 1'b1;
        busy_seen       = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clck);
            bus.load  = 1'b0;
            bus.start = 1'b0;
            if (bus.busy || bus.gate) busy_seen++;
        end
        n_vec++; if (busy_seen !== 0) begin n_err++; $display("FAIL same_cycle_no_window: got %0d busy cycles want 0", busy_seen); end
        sb.push_back('{gate_cycles: 16, edges: 2, period: 8});
        bus.start = 1'b1;
        run_window(100, -1, w);
        e = sb.pop_front();
        n_vec++; if (w.gate_hi !== e.gate_cycles) begin n_err++; $display("FAIL same_cycle_cfg_gate_len: got %0d want %0d", w.gate_hi, e.gate_cycles); end
        n_vec++; if (w.per_min !== e.period || w.per_max !== e.period) begin n_err++; $display("FAIL same_cycle_cfg_period: got %0d..%0d want %0d", w.per_min, w.per_max, e.period); end
        n_vec++; if (w.dut_cnt !== e.edges) begin n_err++; $display("FAIL same_cycle_cfg_edge_cnt: got %0d want %0d", w.dut_cnt, e.edges); end
        @(negedge clck);
    endtask

    task automatic test_reset_mid_window();
        int done_seen;
        int active;
        do_load(5, 100);
        bus.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clck);
            bus.start = 1'b0;
        end
        n_vec++; if (bus.gate !== 1'b1) begin n_err++; $display("FAIL rst_mid_window_open: got %0b want 1", bus.gate); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({bus.sigout, bus.gate, bus.busy, bus.done} !== 4'b0000) begin n_err++; $display("FAIL rst_mid_outputs: got %b want 0000", {bus.sigout, bus.gate, bus.busy, bus.done}); end
        n_vec++; if (bus.edge_cnt !== '0) begin n_err++; $display("FAIL rst_mid_edge_cnt: got %0d want 0", bus.edge_cnt); end
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clck);
            if (bus.done) done_seen++;
        end
        rst_n     = 1'b1;
        bus.start = 1'b1;
        active    = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clck);
            bus.start = 1'b0;
            if (bus.done) done_seen++;
            if (bus.busy || bus.gate) active++;
        end
        n_vec++; if (done_seen !== 0) begin n_err++; $display("FAIL rst_mid_no_done: got %0d want 0", done_seen); end
        n_vec++; if (active !== 0) begin n_err++; $display("FAIL rst_mid_start_ignored: got %0d want 0", active); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hp_zero();
        test_gl_zero();
        test_run_ignore();
        test_load_start_same();
        test_reset_mid_window();
        n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_drained: got %0d want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
